// File: rtl/hdlc_rx_frontend.sv
// HDLC receive front-end: flag/abort detection, zero removal, byte assembly.
// Optional line-idle detector enabled by defining RX_IDLE_DETECT_EN.
module hdlc_rx_frontend #(
    parameter int FRAME_MIN_BYTES = 1
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       RxEN,
    input  logic       Rx,
    output logic       Rx_FlagDetect,
    output logic       Rx_AbortDetect,
    output logic       Rx_ValidFrame,
    output logic [7:0] Rx_Data,
    output logic       Rx_NewByte,
    output logic       Rx_EoF,
`ifdef RX_IDLE_DETECT_EN
    output logic       Rx_NonAligned,
    output logic       Rx_IdleDetect
`else
    output logic       Rx_NonAligned
`endif
);

    localparam logic [7:0] FLAG_PAT  = 8'b0111_1110;
    localparam logic [7:0] ABORT_PAT = 8'b0111_1111;
    localparam logic [7:0] MIN_BYTES = 8'(FRAME_MIN_BYTES);

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  win_q, win_d;
    logic [2:0]  ones_q, ones_d;
    logic [2:0]  bits_q, bits_d;
    logic [6:0]  shift_q, shift_d;
    logic [7:0]  bytes_q, bytes_d;
    logic [2:0]  skip_q, skip_d;
    logic [7:0]  data_q, data_d;
    logic        flag_q, flag_d;
    logic        abort_q, abort_d;
    logic        valid_q, valid_d;
    logic        newb_q, newb_d;
    logic        eof_q, eof_d;
    logic        nal_q, nal_d;

    logic        flag_m;
    logic        abort_m;
    logic        cand;
    logic        keep;
    logic        idle_hit;

    assign flag_m  = (win_q == FLAG_PAT);
    assign abort_m = (win_q == ABORT_PAT);
    // The bit leaving the window is the data candidate, so a flag never
    // reaches the assembler while it is still inside the window.
    assign cand    = win_q[7];

`ifdef RX_IDLE_DETECT_EN
    logic [3:0]  idle_cnt_q, idle_cnt_d;
    logic        idle_q, idle_d;

    assign idle_hit = RxEN && Rx && (idle_cnt_q == 4'hF);

    // Count consecutive raw ones; the level follows one edge behind.
    always_comb begin
        idle_cnt_d = idle_cnt_q;
        idle_d     = idle_q;
        if (RxEN) begin
            if (Rx) begin
                if (idle_cnt_q != 4'hF) begin
                    idle_cnt_d = idle_cnt_q + 4'd1;
                end
                idle_d = (idle_cnt_q == 4'hF);
            end else begin
                idle_cnt_d = 4'd0;
                idle_d     = 1'b0;
            end
        end
    end

    // Idle detector registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            idle_cnt_q <= 4'd0;
            idle_q     <= 1'b0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
            idle_q     <= idle_d;
        end
    end

    assign Rx_IdleDetect = idle_q;
`else
    assign idle_hit = 1'b0;
`endif

    // Framing FSM, zero removal and byte assembly.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        ones_d  = ones_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        bytes_d = bytes_q;
        skip_d  = skip_q;
        data_d  = data_q;
        flag_d  = 1'b0;
        abort_d = 1'b0;
        newb_d  = 1'b0;
        eof_d   = 1'b0;
        nal_d   = 1'b0;
        keep    = 1'b0;
        if (RxEN) begin
            win_d   = {win_q[6:0], Rx};
            flag_d  = flag_m;
            abort_d = abort_m;
            unique case (state_q)
                HUNT: begin
                    if (flag_m) begin
                        state_d = FRAME;
                        ones_d  = 3'd0;
                        bits_d  = 3'd0;
                        shift_d = 7'd0;
                        bytes_d = 8'd0;
                        // The rest of the flag still has to drain out.
                        skip_d  = 3'd7;
                    end
                end
                FRAME: begin
                    if (flag_m) begin
                        if (bytes_q >= MIN_BYTES) begin
                            eof_d   = 1'b1;
                            nal_d   = (bits_q != 3'd0);
                            state_d = HUNT;
                        end else begin
                            ones_d  = 3'd0;
                            bits_d  = 3'd0;
                            shift_d = 7'd0;
                            bytes_d = 8'd0;
                            skip_d  = 3'd7;
                        end
                    end else if (abort_m || idle_hit) begin
                        state_d = HUNT;
                    end else if (skip_q != 3'd0) begin
                        skip_d = skip_q - 3'd1;
                    end else begin
                        if (cand) begin
                            keep = 1'b1;
                            if (ones_q != 3'd7) begin
                                ones_d = ones_q + 3'd1;
                            end
                        end else begin
                            keep   = (ones_q != 3'd5);
                            ones_d = 3'd0;
                        end
                        if (keep) begin
                            shift_d = {shift_q[5:0], cand};
                            bits_d  = bits_q + 3'd1;
                            if (bits_q == 3'd7) begin
                                data_d = {shift_q, cand};
                                newb_d = 1'b1;
                                if (bytes_q != 8'hFF) begin
                                    bytes_d = bytes_q + 8'd1;
                                end
                            end
                        end
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        // An abort keeps the frame valid for the pulse cycle itself.
        valid_d = (state_d == FRAME) ||
                  (RxEN && abort_m && (state_q == FRAME));
    end

    // State and output registers.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= HUNT;
            win_q   <= 8'd0;
            ones_q  <= 3'd0;
            bits_q  <= 3'd0;
            shift_q <= 7'd0;
            bytes_q <= 8'd0;
            skip_q  <= 3'd0;
            data_q  <= 8'd0;
            flag_q  <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            newb_q  <= 1'b0;
            eof_q   <= 1'b0;
            nal_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            ones_q  <= ones_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            bytes_q <= bytes_d;
            skip_q  <= skip_d;
            data_q  <= data_d;
            flag_q  <= flag_d;
            abort_q <= abort_d;
            valid_q <= valid_d;
            newb_q  <= newb_d;
            eof_q   <= eof_d;
            nal_q   <= nal_d;
        end
    end

    assign Rx_FlagDetect  = flag_q;
    assign Rx_AbortDetect = abort_q;
    assign Rx_ValidFrame  = valid_q;
    assign Rx_Data        = data_q;
    assign Rx_NewByte     = newb_q;
    assign Rx_EoF         = eof_q;
    assign Rx_NonAligned  = nal_q;

endmodule
